// File: rtl/baud_gen_ovs.sv
// baud_gen_ovs
// Programmable baud-rate generator with oversampling strobes.
//
// A period counter (cnt) reloads from the committed divisor, so one
// oversample tick is produced every divisor+1 cycles. An oversample counter
// (ovs_cnt) counts those ticks to derive a mid-bit strobe and a bit-rate
// strobe. The divisor is written as two bytes: DIV_LO only fills a staging
// register, and the DIV_HI write commits both halves in a single cycle, so
// the counter never runs with a half-updated divisor.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   wr_en        register write strobe
//   ioaddr[1:0]  register address (00 CTRL, 01 reserved, 10 DIV_LO, 11 DIV_HI)
//   wdata[7:0]   write data
//   rdata[7:0]   read data, combinational from ioaddr
//   rx_sync      one-cycle pulse that restarts the tick phase
//   sample_tick  oversample strobe, period divisor+1
//   mid_tick     strobe on oversample tick OVS/2 of each bit
//   baud_tick    bit-rate strobe, period OVS*(divisor+1)
module baud_gen_ovs #(
  parameter int               DIV_W   = 16,
  parameter int               OVS     = 16,
  parameter logic [DIV_W-1:0] DIV_RST = {DIV_W{1'b1}}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] ioaddr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       rx_sync,
  output logic       sample_tick,
  output logic       mid_tick,
  output logic       baud_tick
);

  localparam int               OVS_W    = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

  logic [DIV_W-1:0] divisor;
  logic [7:0]       lo_stage;
  logic             run;
  logic [DIV_W-1:0] cnt;
  logic [OVS_W-1:0] ovs_cnt;

  logic             wr_ctrl;
  logic             wr_lo;
  logic             wr_hi;
  logic             restart;
  logic [15:0]      div_cat;
  logic [DIV_W-1:0] div_wr;
  logic [DIV_W-1:0] reload_val;

  assign wr_ctrl = wr_en && (ioaddr == 2'b00);
  assign wr_lo   = wr_en && (ioaddr == 2'b10);
  assign wr_hi   = wr_en && (ioaddr == 2'b11);

  // Any of these realigns the tick phase to "now".
  assign restart = rx_sync || (wr_ctrl && wdata[1]) || wr_hi;

  assign div_cat = {wdata, lo_stage};
  assign div_wr  = div_cat[DIV_W-1:0];

  // On a commit the new period starts at the commit edge, so the reload
  // must use the value being written rather than the old divisor.
  assign reload_val = wr_hi ? div_wr : divisor;

  // Register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor  <= DIV_RST;
      lo_stage <= DIV_RST[7:0];
      run      <= 1'b1;
    end else begin
      if (wr_ctrl) run      <= wdata[0];
      if (wr_lo)   lo_stage <= wdata;
      if (wr_hi)   divisor  <= div_wr;
    end
  end

  // Period and oversample counters with registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= DIV_RST;
      ovs_cnt     <= '0;
      sample_tick <= 1'b0;
      mid_tick    <= 1'b0;
      baud_tick   <= 1'b0;
    end else if (restart) begin
      // Restart wins over the terminal-count path and also applies while
      // stopped, so a stopped generator resumes from a clean phase.
      cnt         <= reload_val;
      ovs_cnt     <= '0;
      sample_tick <= 1'b0;
      mid_tick    <= 1'b0;
      baud_tick   <= 1'b0;
    end else if (run) begin
      if (cnt == '0) begin
        cnt         <= divisor;
        sample_tick <= 1'b1;
        mid_tick    <= (ovs_cnt == OVS_MID);
        baud_tick   <= (ovs_cnt == OVS_LAST);
        ovs_cnt     <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
      end else begin
        cnt         <= cnt - DIV_W'(1);
        sample_tick <= 1'b0;
        mid_tick    <= 1'b0;
        baud_tick   <= 1'b0;
      end
    end else begin
      // Stopped: counters hold so the phase resumes where it left off.
      sample_tick <= 1'b0;
      mid_tick    <= 1'b0;
      baud_tick   <= 1'b0;
    end
  end

  // Read mux.
  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      2'b00:   rdata = {7'b0, run};
      2'b10:   rdata = lo_stage;
      2'b11:   rdata = 8'(divisor >> 8);
      default: rdata = 8'h00;
    endcase
  end

endmodule
